// File: rtl/wb_stage.sv
// Write-back stage: retires instructions from MEM, extracts load data and drives
// the regfile write port, difftest PC and retired-instruction counter.
module wb_stage #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   alu_res_i,
  input  logic              wben_i,
  input  logic              is_load_i,
  input  logic [XLEN-1:0]   ld_data_i,
  input  logic              ld_valid_i,
  output logic [XLEN-1:0]   wb_data_o,
  output logic [RIDX_W-1:0] wb_rdid_o,
  output logic              wb_wren_o,
  output logic [XLEN-1:0]   pc_wb_o,
  output logic              commit_o,
  output logic              ld_pend_o,
  output logic [63:0]       instret_o
);

  typedef enum logic {IDLE, WAIT_LD} state_t;

  state_t            state, state_nx;
  logic [XLEN-1:0]   pc_q;
  logic [RIDX_W-1:0] rd_q;
  logic [2:0]        f3_q;
  logic [2:0]        off_q;
  logic              wben_q;

  logic              transfer;
  logic              latch;
  logic              commit_nx;
  logic [XLEN-1:0]   res_nx;
  logic [XLEN-1:0]   pc_nx;
  logic [RIDX_W-1:0] rd_nx;
  logic              wben_nx;

  logic unused_instr;
  assign unused_instr = ^{instr_i[31:15], instr_i[6:0]};

  // Bytes shifted in past the top of the doubleword read as zero.
  function automatic logic [63:0] ld_ext(
    input logic [2:0]  f3,
    input logic [2:0]  off,
    input logic [63:0] d
  );
    logic [63:0] sh;
    sh = d >> {off, 3'b000};
    case (f3)
      3'b000:  ld_ext = {{56{sh[7]}}, sh[7:0]};
      3'b001:  ld_ext = {{48{sh[15]}}, sh[15:0]};
      3'b010:  ld_ext = {{32{sh[31]}}, sh[31:0]};
      3'b011:  ld_ext = sh;
      3'b100:  ld_ext = {56'b0, sh[7:0]};
      3'b101:  ld_ext = {48'b0, sh[15:0]};
      3'b110:  ld_ext = {32'b0, sh[31:0]};
      default: ld_ext = 64'b0;
    endcase
  endfunction

  assign mem_ready_o = ~rst & (state == IDLE);
  assign transfer    = mem_valid_i & mem_ready_o;
  assign ld_pend_o   = (state == WAIT_LD);

  always_comb begin
    state_nx  = state;
    commit_nx = 1'b0;
    latch     = 1'b0;
    res_nx    = alu_res_i;
    pc_nx     = pc_i;
    rd_nx     = instr_i[7 +: RIDX_W];
    wben_nx   = wben_i;
    case (state)
      IDLE: begin
        if (transfer) begin
          if (!is_load_i) begin
            commit_nx = 1'b1;
          end else if (ld_valid_i) begin
            commit_nx = 1'b1;
            res_nx    = ld_ext(instr_i[14:12], alu_res_i[2:0], ld_data_i);
          end else begin
            latch    = 1'b1;
            state_nx = WAIT_LD;
          end
        end
      end
      WAIT_LD: begin
        pc_nx   = pc_q;
        rd_nx   = rd_q;
        wben_nx = wben_q;
        res_nx  = ld_ext(f3_q, off_q, ld_data_i);
        if (ld_valid_i) begin
          commit_nx = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      rd_q   <= '0;
      f3_q   <= '0;
      off_q  <= '0;
      wben_q <= 1'b0;
    end else if (latch) begin
      pc_q   <= pc_i;
      rd_q   <= instr_i[7 +: RIDX_W];
      f3_q   <= instr_i[14:12];
      off_q  <= alu_res_i[2:0];
      wben_q <= wben_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_o <= '0;
      wb_rdid_o <= '0;
      wb_wren_o <= 1'b0;
      pc_wb_o   <= '0;
      commit_o  <= 1'b0;
      instret_o <= '0;
    end else begin
      commit_o  <= commit_nx;
      wb_wren_o <= commit_nx & wben_nx & (rd_nx != '0);
      if (commit_nx) begin
        wb_data_o <= res_nx;
        wb_rdid_o <= rd_nx;
        pc_wb_o   <= pc_nx;
        instret_o <= instret_o + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for single-cycle retirements
// plus sequences for late load data and reset during a pending load.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [63:0] alu_res;
  logic        wben;
  logic        is_load;
  logic [63:0] ld_data;
  logic        ld_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rdid;
  logic        wb_wren;
  logic [63:0] pc_wb;
  logic        commit;
  logic        ld_pend;
  logic [63:0] instret;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_instret = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid_i (mem_valid),
    .mem_ready_o (mem_ready),
    .pc_i        (pc),
    .instr_i     (instr),
    .alu_res_i   (alu_res),
    .wben_i      (wben),
    .is_load_i   (is_load),
    .ld_data_i   (ld_data),
    .ld_valid_i  (ld_valid),
    .wb_data_o   (wb_data),
    .wb_rdid_o   (wb_rdid),
    .wb_wren_o   (wb_wren),
    .pc_wb_o     (pc_wb),
    .commit_o    (commit),
    .ld_pend_o   (ld_pend),
    .instret_o   (instret)
  );

  typedef struct {
    string       name;
    logic        wben;
    logic        is_load;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] alu_res;
    logic [63:0] ld_data;
    logic [63:0] exp_data;
    logic        exp_wren;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3,
                                     input logic [4:0] rd);
    mk = {17'b0, f3, rd, 7'b0000011};
  endfunction

  task automatic idle_in();
    mem_valid = 0;
    ld_valid  = 0;
    is_load   = 0;
    wben      = 0;
  endtask

  initial begin
    vt[0]  = '{"addi_x5", 1, 0, 3'b000, 5'd5, 64'h2A, 64'h0,
               64'h2A, 1};
    vt[1]  = '{"rd0", 1, 0, 3'b000, 5'd0, 64'hFF, 64'h0,
               64'hFF, 0};
    vt[2]  = '{"lb_off3", 1, 1, 3'b000, 5'd6, 64'h1003,
               64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1};
    vt[3]  = '{"lbu_off3", 1, 1, 3'b100, 5'd6, 64'h1003,
               64'h0000_0000_8000_0000, 64'h80, 1};
    vt[4]  = '{"lh_off0", 1, 1, 3'b001, 5'd7, 64'h2000,
               64'h0000_0000_0000_8001, 64'hFFFF_FFFF_FFFF_8001, 1};
    vt[5]  = '{"lw_off4", 1, 1, 3'b010, 5'd8, 64'h2004,
               64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 1};
    vt[6]  = '{"lwu_off4", 1, 1, 3'b110, 5'd9, 64'h2004,
               64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 1};
    vt[7]  = '{"ld_off0", 1, 1, 3'b011, 5'd10, 64'h3000,
               64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1};
    vt[8]  = '{"lw_off6", 1, 1, 3'b010, 5'd11, 64'h3006,
               64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_1234, 1};
    vt[9]  = '{"rsvd111", 1, 1, 3'b111, 5'd12, 64'h3000,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1};
    vt[10] = '{"lhu_off7", 1, 1, 3'b101, 5'd13, 64'h3007,
               64'hAB00_0000_0000_0000, 64'hAB, 1};
    vt[11] = '{"nowben", 0, 0, 3'b000, 5'd7, 64'h5555, 64'h0,
               64'h5555, 0};
    vt[12] = '{"lh_off2", 1, 1, 3'b001, 5'd31, 64'h4002,
               64'h0000_0000_FFFE_0000, 64'hFFFF_FFFF_FFFF_FFFE, 1};

    rst = 1;
    idle_in();
    pc = 0; instr = 0; alu_res = 0; ld_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'b0, mem_ready}, 64'd0);
    chk("rst_commit", {63'b0, commit}, 64'd0);
    chk("rst_wren", {63'b0, wb_wren}, 64'd0);
    chk("rst_pend", {63'b0, ld_pend}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_data", wb_data, 64'd0);
    chk("rst_pc", pc_wb, 64'd0);
    rst = 0;
    #1 chk("ready_after_rst", {63'b0, mem_ready}, 64'd1);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      mem_valid = 1;
      ld_valid  = vt[i].is_load;
      is_load   = vt[i].is_load;
      wben      = vt[i].wben;
      instr     = mk(vt[i].f3, vt[i].rd);
      alu_res   = vt[i].alu_res;
      ld_data   = vt[i].ld_data;
      pc        = 64'h8000_0000 + 64'(4 * i);
      @(posedge clk);
      exp_instret++;
      @(negedge clk);
      idle_in();
      chk({vt[i].name, "_data"}, wb_data, vt[i].exp_data);
      chk({vt[i].name, "_rdid"}, {59'b0, wb_rdid}, {59'b0, vt[i].rd});
      chk({vt[i].name, "_wren"}, {63'b0, wb_wren},
          {63'b0, vt[i].exp_wren});
      chk({vt[i].name, "_commit"}, {63'b0, commit}, 64'd1);
      chk({vt[i].name, "_pc"}, pc_wb, 64'h8000_0000 + 64'(4 * i));
      chk({vt[i].name, "_instret"}, instret, exp_instret);
    end

    // No transfer: pulses drop, write-port fields hold.
    @(negedge clk);
    chk("idle_commit", {63'b0, commit}, 64'd0);
    chk("idle_wren", {63'b0, wb_wren}, 64'd0);
    chk("idle_hold_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("idle_hold_rdid", {59'b0, wb_rdid}, 64'd31);
    chk("idle_instret", instret, exp_instret);

    // lhu off=2 with data three cycles late; MEM offers junk meanwhile.
    mem_valid = 1; is_load = 1; wben = 1; ld_valid = 0;
    instr = mk(3'b101, 5'd20); alu_res = 64'h5002;
    pc = 64'h9000_0000; ld_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      alu_res = 64'h7777; instr = mk(3'b011, 5'd3);
      pc = 64'hDEAD; is_load = 0;
      chk("late_ready", {63'b0, mem_ready}, 64'd0);
      chk("late_pend", {63'b0, ld_pend}, 64'd1);
      chk("late_nocommit", {63'b0, commit}, 64'd0);
    end
    @(negedge clk);
    chk("late_pend3", {63'b0, ld_pend}, 64'd1);
    mem_valid = 0; ld_valid = 1;
    ld_data = 64'h0000_0000_BEEF_0000;
    @(posedge clk);
    exp_instret++;
    @(negedge clk);
    idle_in();
    chk("late_commit", {63'b0, commit}, 64'd1);
    chk("late_data", wb_data, 64'hBEEF);
    chk("late_rdid", {59'b0, wb_rdid}, 64'd20);
    chk("late_wren", {63'b0, wb_wren}, 64'd1);
    chk("late_pc", pc_wb, 64'h9000_0000);
    chk("late_pend_off", {63'b0, ld_pend}, 64'd0);
    chk("late_ready_back", {63'b0, mem_ready}, 64'd1);
    chk("late_instret", instret, exp_instret);
    @(negedge clk);
    chk("late_one_pulse", {63'b0, commit}, 64'd0);

    // Reset while a load is pending drops it.
    mem_valid = 1; is_load = 1; wben = 1; ld_valid = 0;
    instr = mk(3'b011, 5'd9); alu_res = 64'h6000; pc = 64'hA000;
    @(posedge clk);
    @(negedge clk);
    idle_in();
    chk("rstw_pend", {63'b0, ld_pend}, 64'd1);
    rst = 1;
    #1 chk("rstw_ready_in_rst", {63'b0, mem_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    ld_valid = 1; ld_data = 64'h1111;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 0;
    chk("rstw_nocommit", {63'b0, commit}, 64'd0);
    chk("rstw_wren", {63'b0, wb_wren}, 64'd0);
    chk("rstw_instret", instret, 64'd0);
    chk("rstw_pend", {63'b0, ld_pend}, 64'd0);
    chk("rstw_ready", {63'b0, mem_ready}, 64'd1);
    chk("rstw_pc", pc_wb, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
